// File: rtl/dmem_access_ctrl.sv
// Memory-stage data-memory access controller: runs the req/gnt/rvalid handshake
// with a variable-latency data memory and stalls the pipeline until it completes.
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        xm_valid_i,
  input  logic        xm_is_load_i,
  input  logic        xm_is_store_i,
  input  logic [31:0] xm_addr_i,
  input  logic [31:0] xm_wdata_i,
  input  logic [4:0]  xm_rd_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t r_state;
  state_t w_next_state;

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_we;
  logic [4:0]       r_rd;
  logic             r_req;
  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_data;
  logic             r_err;

  logic w_is_mem_op;
  logic w_aligned;
  logic w_start;
  logic w_bad;
  logic w_done;
  logic w_limit;
  logic w_timeout;
  logic w_stall;
  logic w_wb_load;

  // Exactly one of load/store, word-aligned: anything else valid but touching
  // memory is rejected in IDLE without stalling the pipeline.
  assign w_is_mem_op = xm_is_load_i | xm_is_store_i;
  assign w_aligned   = (xm_addr_i[1:0] == 2'b00);
  assign w_start     = xm_valid_i & (xm_is_load_i ^ xm_is_store_i) & w_aligned;
  assign w_bad       = xm_valid_i & w_is_mem_op & ~w_start;
  assign w_limit     = (r_cnt == CNT_LIMIT);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next_state = S_REQ;
          w_stall      = 1'b1;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        // rvalid before grant is meaningless and therefore ignored
        if (mem_gnt_i && (r_we || mem_rvalid_i)) begin
          w_done       = 1'b1;
          w_next_state = S_RESP;
        end else if (w_limit) begin
          w_timeout    = 1'b1;
          w_next_state = S_RESP;
        end else if (mem_gnt_i) begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (mem_rvalid_i) begin
          w_done       = 1'b1;
          w_next_state = S_RESP;
        end else if (w_limit) begin
          w_timeout    = 1'b1;
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        // Leave unconditionally: the completed instruction is still in XM here.
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_wb_load = w_done & ~r_we & (r_rd != 5'd0);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_rd       <= '0;
      r_req      <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_start) begin
        r_cnt   <= '0;
        r_addr  <= {xm_addr_i[31:2], 2'b00};
        r_wdata <= xm_wdata_i;
        r_we    <= xm_is_store_i;
        r_rd    <= xm_rd_i;
      end else if (r_state == S_REQ || r_state == S_WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      r_req      <= (w_next_state == S_REQ);
      r_err      <= ((r_state == S_IDLE) & w_bad) | w_timeout;
      r_wb_valid <= w_wb_load;
      r_wb_rd    <= w_wb_load ? r_rd : 5'd0;
      r_wb_data  <= w_wb_load ? mem_rdata_i : 32'd0;
    end
  end

  assign stall_o     = w_stall;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign wb_valid_o  = r_wb_valid;
  assign wb_rd_o     = r_wb_rd;
  assign wb_data_o   = r_wb_data;
  assign err_o       = r_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: scripted memory latencies per access,
// per-access counts of stall/request/writeback/error cycles against hand values.
module tb_dmem_access_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        xm_valid_i, xm_is_load_i, xm_is_store_i;
  logic [31:0] xm_addr_i, xm_wdata_i;
  logic [4:0]  xm_rd_i;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .clk(clk), .n_reset(n_reset),
    .xm_valid_i(xm_valid_i), .xm_is_load_i(xm_is_load_i), .xm_is_store_i(xm_is_store_i),
    .xm_addr_i(xm_addr_i), .xm_wdata_i(xm_wdata_i), .xm_rd_i(xm_rd_i),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  int          stall_cyc, req_cyc, wb_cyc, err_cyc, bad_req;
  logic [4:0]  wb_rd_seen;
  logic [31:0] wb_data_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    xm_valid_i    = 1'b0;
    xm_is_load_i  = 1'b0;
    xm_is_store_i = 1'b0;
    xm_addr_i     = 32'd0;
    xm_wdata_i    = 32'd0;
    xm_rd_i       = 5'd0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = 32'hBAD0BAD0;
  endtask

  // Presents one XM instruction, holds it while stalled, and plays a memory that
  // grants after gnt_delay request cycles and returns data rv_delay cycles after grant.
  task automatic run_access(input logic ld, input logic st, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd,
                            input int gnt_delay, input int rv_delay,
                            input logic [31:0] rdata);
    int          req_n;
    int          gnt_cyc;
    logic        released;
    logic [31:0] exp_addr;
    stall_cyc = 0; req_cyc = 0; wb_cyc = 0; err_cyc = 0; bad_req = 0;
    wb_rd_seen = 5'd0; wb_data_seen = 32'd0;
    req_n = 0; gnt_cyc = -1; released = 1'b0;
    exp_addr = {addr[31:2], 2'b00};
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        xm_valid_i = 1'b1; xm_is_load_i = ld; xm_is_store_i = st;
        xm_addr_i = addr; xm_wdata_i = wdata; xm_rd_i = rd;
      end else if (released) begin
        xm_valid_i = 1'b0; xm_is_load_i = 1'b0; xm_is_store_i = 1'b0;
      end
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'hBAD0BAD0;
      if (mem_req_o) begin
        req_n++;
        if (req_n == gnt_delay + 1) begin
          mem_gnt_i = 1'b1;
          gnt_cyc   = cyc;
        end
      end
      if (ld && !st && gnt_cyc >= 0 && cyc == gnt_cyc + rv_delay) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
      end
      @(negedge clk);
      if (stall_o) stall_cyc++;
      else released = 1'b1;
      if (mem_req_o) begin
        req_cyc++;
        if (mem_addr_o !== exp_addr || mem_we_o !== st || (st && mem_wdata_o !== wdata))
          bad_req++;
      end
      if (wb_valid_o) begin
        wb_cyc++;
        wb_rd_seen   = wb_rd_o;
        wb_data_seen = wb_data_o;
      end
      if (err_o) err_cyc++;
    end
  endtask

  initial begin
    idle_inputs();
    n_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;
    @(negedge clk);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_req",   32'(mem_req_o), 32'd0);
    check("rst_wb",    32'(wb_valid_o), 32'd0);
    check("rst_err",   32'(err_o), 32'd0);
    check("rst_addr",  mem_addr_o, 32'd0);

    // Zero-wait load
    run_access(1'b1, 1'b0, 32'h100, 32'd0, 5'd5, 0, 0, 32'hDEADBEEF);
    check("zw_stall",   32'(stall_cyc), 32'd2);
    check("zw_req",     32'(req_cyc), 32'd1);
    check("zw_reqbits", 32'(bad_req), 32'd0);
    check("zw_wbcnt",   32'(wb_cyc), 32'd1);
    check("zw_wbrd",    32'(wb_rd_seen), 32'd5);
    check("zw_wbdata",  wb_data_seen, 32'hDEADBEEF);
    check("zw_err",     32'(err_cyc), 32'd0);

    // Store, grant after 3 wait cycles
    run_access(1'b0, 1'b1, 32'h40, 32'h12345678, 5'd9, 3, 0, 32'd0);
    check("st_req",    32'(req_cyc), 32'd4);
    check("st_stable", 32'(bad_req), 32'd0);
    check("st_stall",  32'(stall_cyc), 32'd5);
    check("st_wb",     32'(wb_cyc), 32'd0);
    check("st_err",    32'(err_cyc), 32'd0);

    // Load, rvalid 4 cycles after grant
    run_access(1'b1, 1'b0, 32'h204, 32'd0, 5'd7, 0, 4, 32'h0BADCAFE);
    check("lw_stall",  32'(stall_cyc), 32'd6);
    check("lw_wbcnt",  32'(wb_cyc), 32'd1);
    check("lw_wbrd",   32'(wb_rd_seen), 32'd7);
    check("lw_wbdata", wb_data_seen, 32'h0BADCAFE);

    // Same latency to x0: no writeback
    run_access(1'b1, 1'b0, 32'h208, 32'd0, 5'd0, 0, 4, 32'h55AA55AA);
    check("r0_stall", 32'(stall_cyc), 32'd6);
    check("r0_wb",    32'(wb_cyc), 32'd0);
    check("r0_err",   32'(err_cyc), 32'd0);

    // Misaligned load
    run_access(1'b1, 1'b0, 32'h102, 32'd0, 5'd4, 0, 0, 32'h11111111);
    check("mis_stall", 32'(stall_cyc), 32'd0);
    check("mis_req",   32'(req_cyc), 32'd0);
    check("mis_err",   32'(err_cyc), 32'd1);
    check("mis_wb",    32'(wb_cyc), 32'd0);

    // Illegal: load and store together
    run_access(1'b1, 1'b1, 32'h80, 32'd0, 5'd4, 0, 0, 32'h22222222);
    check("ill_stall", 32'(stall_cyc), 32'd0);
    check("ill_req",   32'(req_cyc), 32'd0);
    check("ill_err",   32'(err_cyc), 32'd1);

    // Memory never grants: timeout
    run_access(1'b1, 1'b0, 32'h300, 32'd0, 5'd6, 1000, 0, 32'h33333333);
    check("to_stall", 32'(stall_cyc), 32'd9);
    check("to_req",   32'(req_cyc), 32'(TO));
    check("to_err",   32'(err_cyc), 32'd1);
    check("to_wb",    32'(wb_cyc), 32'd0);

    // Late response after the timeout is ignored
    @(posedge clk); #1;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFEEDFACE;
    @(posedge clk); #1;
    @(negedge clk);
    check("late_wb",    32'(wb_valid_o), 32'd0);
    check("late_err",   32'(err_o), 32'd0);
    check("late_stall", 32'(stall_cyc == 9 ? stall_o : 1'b1), 32'd0);
    idle_inputs();

    // Reset while waiting for rvalid
    @(posedge clk); #1;
    xm_valid_i = 1'b1; xm_is_load_i = 1'b1; xm_addr_i = 32'h400; xm_rd_i = 5'd3;
    @(posedge clk); #1;
    mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    @(negedge clk);
    check("rw_wait_stall", 32'(stall_o), 32'd1);
    check("rw_wait_req",   32'(mem_req_o), 32'd0);
    @(posedge clk); #1;
    n_reset = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    n_reset = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77777777;
    @(negedge clk);
    check("rw_stall", 32'(stall_o), 32'd0);
    check("rw_req",   32'(mem_req_o), 32'd0);
    check("rw_we",    32'(mem_we_o), 32'd0);
    check("rw_addr",  mem_addr_o, 32'd0);
    check("rw_wb",    32'(wb_valid_o), 32'd0);
    check("rw_err",   32'(err_o), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("rw_post_wb", 32'(wb_valid_o), 32'd0);

    // Next load after reset proceeds normally
    run_access(1'b1, 1'b0, 32'h500, 32'd0, 5'd9, 0, 0, 32'hCAFEF00D);
    check("pr_stall",  32'(stall_cyc), 32'd2);
    check("pr_wbrd",   32'(wb_rd_seen), 32'd9);
    check("pr_wbdata", wb_data_seen, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage data-memory access controller for the 5-stage pipeline. It takes load/store operations presented by the XM stage, runs a request/grant/response handshake with a variable-latency data memory, and holds the pipeline frozen through `stall_o` until the access completes. Load results go to the MW stage through a registered writeback port. It is the counterpart of the load-use bubble logic: that logic schedules around load latency, and this block produces the latency and ends it.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum number of cycles spent in REQ+WAIT before the access is aborted.
- `CNT_W`, default 7: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports (one clock; reset is synchronous and active-low, ports named as the codebase does):
- `clk` in 1: clock. All state changes on the rising edge.
- `n_reset` in 1: synchronous active-low reset.
- `xm_valid_i` in 1: XM stage holds a valid instruction.
- `xm_is_load_i` in 1: XM instruction is a load.
- `xm_is_store_i` in 1: XM instruction is a store.
- `xm_addr_i` in 32: byte address.
- `xm_wdata_i` in 32: store data.
- `xm_rd_i` in 5: load destination register.
- `stall_o` out 1: freezes the PC, FD, DX and XM registers.
- `mem_req_o` out 1: memory request (registered).
- `mem_we_o` out 1: 1 for store, 0 for load.
- `mem_addr_o` out 32: word-aligned address.
- `mem_wdata_o` out 32: store data.
- `mem_gnt_i` in 1: memory accepts the request this cycle.
- `mem_rvalid_i` in 1: load data valid.
- `mem_rdata_i` in 32: load data.
- `wb_valid_o` out 1: load result valid toward MW.
- `wb_rd_o` out 5: destination register.
- `wb_data_o` out 32: load data.
- `err_o` out 1: one-cycle pulse on misaligned, illegal, or timed-out access.

## Operation
- Start condition: `start = xm_valid_i & (xm_is_load_i ^ xm_is_store_i) & (xm_addr_i[1:0]==0)`, evaluated in IDLE only.
- States:
  - IDLE: on `start`, latch addr, wdata, we (= is_store) and rd, clear the counter, and go to REQ.
  - REQ: `mem_req_o`=1. On `mem_gnt_i`:
    - store: go to RESP.
    - load with `mem_rvalid_i` in the same cycle: capture rdata and go to RESP.
    - load otherwise: go to WAIT.
  - WAIT: `mem_req_o`=0. On `mem_rvalid_i`, capture rdata and go to RESP.
  - RESP: one cycle, then IDLE unconditionally. This prevents re-triggering on the XM instruction that is still held.
- `stall_o` is combinational: `(IDLE & start) | REQ | WAIT`. It is 0 in RESP so the pipeline advances at the end of RESP.
- `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` come from registers. `mem_addr_o[1:0]` is always 0. Address and data stay stable while `mem_req_o`=1.
- Writeback outputs are registered and valid only during RESP, only for a completed load, and only when rd≠0. `wb_data_o` holds the captured rdata. Otherwise `wb_valid_o`=0, `wb_rd_o`=0 and `wb_data_o`=0.
- Timeout: the counter increments in every REQ/WAIT cycle. When it reaches TIMEOUT_CYCLES-1 without completion:
  - go to RESP with `err_o`=1 and no writeback.
  - drop `mem_req_o`.
  - ignore any late `mem_rvalid_i` or `mem_gnt_i` arriving in RESP or IDLE.
- Misaligned (`addr[1:0]≠0`) or illegal (`is_load & is_store`) access while `xm_valid_i`=1 in IDLE:
  - no memory request and no stall.
  - `err_o` pulses on the next cycle.
  - no writeback.
- `mem_rvalid_i` in REQ before grant is ignored.

## Timing
- Reset (`n_reset`=0 at an edge): state IDLE, counter 0, and every output 0 on the next cycle. A reset mid-access abandons it: `mem_req_o` falls after that edge and no writeback occurs.
- Zero-wait memory (gnt and rvalid asserted in the first REQ cycle):
  - cycle 0 IDLE, start, stall=1
  - cycle 1 REQ, stall=1
  - cycle 2 RESP, stall=0, wb valid
  - Total: 2 stall cycles.
- Each extra grant-wait cycle or rvalid-wait cycle adds one stall cycle.
- A store completes in RESP on the cycle after grant.
- `err_o` is a single cycle, registered, and never high in two consecutive cycles for one access.

## Test plan
- Zero-wait load: addr 0x100, rd=5, gnt and rvalid in the same cycle with rdata 0xDEADBEEF → stall high exactly 2 cycles; `wb_valid_o`=1, `wb_rd_o`=5, `wb_data_o`=0xDEADBEEF for 1 cycle.
- Store with gnt delayed 3 cycles, addr 0x40, data 0x12345678 → `mem_req_o` high 4 cycles with stable addr/data and `mem_we_o`=1; stall 5 cycles; no writeback.
- Load with rvalid 4 cycles after gnt → stall covers all of WAIT; data captured on the rvalid edge; rd=0 load produces `wb_valid_o`=0.
- Misaligned load addr 0x102 → stall never asserted, `mem_req_o` never asserted, `err_o` one pulse.
- Memory never responds, TIMEOUT_CYCLES=8 → stall lasts 9 cycles, `err_o` pulses in RESP, no writeback; a late rvalid afterwards is ignored.
- `n_reset` low during WAIT → next cycle all outputs 0 and state IDLE; the next load proceeds normally.
